// File: rtl/gear_selector_input_pkg.sv
`default_nettype none
// gear_selector_input_pkg -- mode encoding shared with the gear FSM, input indices, shift interlock.
// Rev 1.0
package gear_selector_input_pkg;

  typedef enum logic [1:0] {
    MODE_P = 2'b00,
    MODE_N = 2'b01,
    MODE_R = 2'b10,
    MODE_D = 2'b11
  } mode_e;

  localparam int unsigned c_NUM_BTN   = 4;
  localparam int unsigned c_NUM_IN    = 5;
  localparam int unsigned c_IDX_P     = 0;
  localparam int unsigned c_IDX_N     = 1;
  localparam int unsigned c_IDX_R     = 2;
  localparam int unsigned c_IDX_D     = 3;
  localparam int unsigned c_IDX_BRAKE = 4;

  // Entering P or N is always safe; leaving P or reversing direction needs the brake.
  function automatic logic shift_allowed(input mode_e cur, input mode_e req, input logic brake);
    logic ok;
    ok = 1'b1;
    if (req == MODE_P || req == MODE_N) begin
      ok = 1'b1;
    end else if (cur == MODE_P) begin
      ok = brake;
    end else if ((cur == MODE_R && req == MODE_D) || (cur == MODE_D && req == MODE_R)) begin
      ok = brake;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/selector_debounce.sv
`default_nettype none
// selector_debounce -- 2-flop synchronizer followed by a stable-count debouncer for one contact.
// Rev 1.0
module selector_debounce #(
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned   CW        = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] c_DEB_MAX = CW'(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Toggle only once the input has differed for DEB_CYCLES counted cycles; counter never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_DEB_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/gear_selector_input.sv
`default_nettype none
// gear_selector_input -- debounced gear-selector buttons to interlocked P/N/R/D command pulses.
// Rev 1.0
module gear_selector_input
  import gear_selector_input_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 8,
  parameter int unsigned STUCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_p,
  input  logic       btn_n,
  input  logic       btn_r,
  input  logic       btn_d,
  input  logic       brake,
  output logic       P,
  output logic       N,
  output logic       R,
  output logic       D,
  output logic [1:0] mode,
  output logic       reject,
  output logic       fault
);

  localparam int unsigned   SW          = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] c_STUCK_MAX = SW'(STUCK_CYCLES);

  logic [c_NUM_IN-1:0]  w_raw;
  logic [c_NUM_IN-1:0]  w_lvl;
  logic [c_NUM_BTN-1:0] w_stuck_hit;

  logic [c_NUM_BTN-1:0] prev_q;
  logic [c_NUM_BTN-1:0] rise_q, rise_d;
  logic [c_NUM_BTN-1:0] cmd_q, cmd_d;
  logic                 reject_q, reject_d;
  logic                 fault_q, fault_d;
  mode_e                mode_q, mode_d;

  logic                 w_req_valid;
  mode_e                w_req_mode;

  assign w_raw[c_IDX_P]     = btn_p;
  assign w_raw[c_IDX_N]     = btn_n;
  assign w_raw[c_IDX_R]     = btn_r;
  assign w_raw[c_IDX_D]     = btn_d;
  assign w_raw[c_IDX_BRAKE] = brake;

  for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_deb
    selector_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (w_raw[gi]),
      .level_o(w_lvl[gi])
    );
  end

  for (genvar gb = 0; gb < c_NUM_BTN; gb++) begin : g_stuck
    logic [SW-1:0] stuck_q, stuck_d;

    always_comb begin
      stuck_d = stuck_q;
      if (!w_lvl[gb]) begin
        stuck_d = '0;
      end else if (stuck_q != c_STUCK_MAX) begin
        stuck_d = stuck_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stuck_q <= '0;
      end else begin
        stuck_q <= stuck_d;
      end
    end

    assign w_stuck_hit[gb] = (stuck_d == c_STUCK_MAX);
  end

  assign rise_d  = w_lvl[c_NUM_BTN-1:0] & ~prev_q;
  assign fault_d = fault_q | (|w_stuck_hit);

  // Priority P > N > R > D; while faulted only P may form a request.
  always_comb begin
    w_req_valid = 1'b0;
    w_req_mode  = MODE_P;
    if (rise_q[c_IDX_P]) begin
      w_req_valid = 1'b1;
      w_req_mode  = MODE_P;
    end else if (!fault_q) begin
      if (rise_q[c_IDX_N]) begin
        w_req_valid = 1'b1;
        w_req_mode  = MODE_N;
      end else if (rise_q[c_IDX_R]) begin
        w_req_valid = 1'b1;
        w_req_mode  = MODE_R;
      end else if (rise_q[c_IDX_D]) begin
        w_req_valid = 1'b1;
        w_req_mode  = MODE_D;
      end
    end
  end

  always_comb begin
    cmd_d    = '0;
    reject_d = 1'b0;
    mode_d   = mode_q;
    if (w_req_valid && (w_req_mode != mode_q)) begin
      if (shift_allowed(mode_q, w_req_mode, w_lvl[c_IDX_BRAKE])) begin
        cmd_d[w_req_mode] = 1'b1;
        mode_d            = w_req_mode;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      rise_q   <= '0;
      cmd_q    <= '0;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
      mode_q   <= MODE_P;
    end else begin
      prev_q   <= w_lvl[c_NUM_BTN-1:0];
      rise_q   <= rise_d;
      cmd_q    <= cmd_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
      mode_q   <= mode_d;
    end
  end

  assign P      = cmd_q[c_IDX_P];
  assign N      = cmd_q[c_IDX_N];
  assign R      = cmd_q[c_IDX_R];
  assign D      = cmd_q[c_IDX_D];
  assign mode   = mode_q;
  assign reject = reject_q;
  assign fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_gear_selector_input.sv
`default_nettype none
// tb_gear_selector_input -- directed vectors with hand-computed expectations, DEB_CYCLES=8, STUCK_CYCLES=64.
// Rev 1.0
module tb_gear_selector_input;

  localparam int unsigned DEB   = 8;
  localparam int unsigned STUCK = 64;
  localparam int          LAT   = 12;

  localparam int O_P = 0, O_N = 1, O_R = 2, O_D = 3, O_REJ = 4, O_FLT = 5;

  logic       clk;
  logic       reset;
  logic       b_p, b_n, b_r, b_d, brake;
  logic       P, N, R, D, reject, fault;
  logic [1:0] mode;

  int n_total;
  int n_bad;
  int first_seen [6];
  int n_seen     [6];
  int multi_hot;

  gear_selector_input #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_p (b_p),
    .btn_n (b_n),
    .btn_r (b_r),
    .btn_d (b_d),
    .brake (brake),
    .P     (P),
    .N     (N),
    .R     (R),
    .D     (D),
    .mode  (mode),
    .reject(reject),
    .fault (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_obs();
    for (int j = 0; j < 6; j++) begin
      first_seen[j] = -1;
      n_seen[j]     = 0;
    end
  endtask

  // Index 0 is the sample just after the first edge following the input change.
  task automatic watch(input int ncyc);
    logic [5:0] obs;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      obs = {fault, reject, D, R, N, P};
      for (int j = 0; j < 6; j++) begin
        if (obs[j] === 1'b1) begin
          if (first_seen[j] < 0) first_seen[j] = i;
          n_seen[j]++;
        end
      end
      if ($countones(obs[4:0]) > 1) multi_hot++;
    end
  endtask

  task automatic idle(input int ncyc);
    clear_obs();
    watch(ncyc);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    multi_hot = 0;
    clear_obs();
    reset = 1'b1;
    b_p = 1'b0; b_n = 1'b0; b_r = 1'b0; b_d = 1'b0;
    brake = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_P", {31'd0, P}, 32'd0);
    check_eq("rst_N", {31'd0, N}, 32'd0);
    check_eq("rst_R", {31'd0, R}, 32'd0);
    check_eq("rst_D", {31'd0, D}, 32'd0);
    check_eq("rst_reject", {31'd0, reject}, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    check_eq("rst_mode", {30'd0, mode}, 32'd0);
    reset = 1'b0;
    idle(20);

    // Clean D press with brake held.
    b_d = 1'b1;
    clear_obs();
    watch(30);
    check_eq("d_first", first_seen[O_D], LAT);
    check_eq("d_count", n_seen[O_D], 1);
    check_eq("d_reject", n_seen[O_REJ], 0);
    check_eq("d_mode", {30'd0, mode}, 32'd3);
    b_d = 1'b0;
    idle(20);

    // Bouncing N: stable runs of 3 cycles never qualify.
    clear_obs();
    for (int k = 0; k < 10; k++) begin
      b_n = (k % 2 == 0);
      watch(3);
    end
    check_eq("bounce_quiet", n_seen[O_P] + n_seen[O_N] + n_seen[O_R] + n_seen[O_D] + n_seen[O_REJ], 0);
    b_n = 1'b1;
    clear_obs();
    watch(30);
    check_eq("n_first", first_seen[O_N], LAT);
    check_eq("n_count", n_seen[O_N], 1);
    check_eq("n_mode", {30'd0, mode}, 32'd1);
    b_n = 1'b0;
    idle(20);

    // Back to P, then R without brake is refused.
    b_p = 1'b1;
    clear_obs();
    watch(30);
    check_eq("p_count", n_seen[O_P], 1);
    check_eq("p_mode", {30'd0, mode}, 32'd0);
    b_p = 1'b0;
    brake = 1'b0;
    idle(20);
    b_r = 1'b1;
    clear_obs();
    watch(30);
    check_eq("rnb_reject_first", first_seen[O_REJ], LAT);
    check_eq("rnb_reject_count", n_seen[O_REJ], 1);
    check_eq("rnb_R", n_seen[O_R], 0);
    check_eq("rnb_mode", {30'd0, mode}, 32'd0);
    b_r = 1'b0;
    brake = 1'b1;
    idle(20);
    b_r = 1'b1;
    clear_obs();
    watch(30);
    check_eq("rb_R", n_seen[O_R], 1);
    check_eq("rb_reject", n_seen[O_REJ], 0);
    check_eq("rb_mode", {30'd0, mode}, 32'd2);
    b_r = 1'b0;
    idle(20);

    // To N, then P and D together: P wins.
    b_n = 1'b1;
    clear_obs();
    watch(30);
    check_eq("n2_mode", {30'd0, mode}, 32'd1);
    b_n = 1'b0;
    idle(20);
    b_p = 1'b1;
    b_d = 1'b1;
    clear_obs();
    watch(30);
    check_eq("pd_P", n_seen[O_P], 1);
    check_eq("pd_D", n_seen[O_D], 0);
    check_eq("pd_reject", n_seen[O_REJ], 0);
    check_eq("pd_mode", {30'd0, mode}, 32'd0);
    b_p = 1'b0;
    b_d = 1'b0;
    idle(20);

    // Stuck D raises sticky fault; afterwards only P is honoured.
    b_d = 1'b1;
    clear_obs();
    watch(100);
    check_eq("stuck_D", n_seen[O_D], 1);
    check_eq("stuck_fault_window",
             {31'd0, (first_seen[O_FLT] >= int'(STUCK)) && (first_seen[O_FLT] <= int'(STUCK) + LAT)}, 32'd1);
    b_d = 1'b0;
    idle(20);
    check_eq("fault_sticky", {31'd0, fault}, 32'd1);
    b_n = 1'b1;
    clear_obs();
    watch(30);
    check_eq("flt_N", n_seen[O_N], 0);
    check_eq("flt_N_reject", n_seen[O_REJ], 0);
    check_eq("flt_N_mode", {30'd0, mode}, 32'd3);
    b_n = 1'b0;
    idle(20);
    b_p = 1'b1;
    clear_obs();
    watch(30);
    check_eq("flt_P", n_seen[O_P], 1);
    check_eq("flt_P_mode", {30'd0, mode}, 32'd0);
    b_p = 1'b0;
    idle(20);

    // Reset in the middle of a D debounce.
    b_d = 1'b1;
    clear_obs();
    watch(5);
    reset = 1'b1;
    watch(3);
    check_eq("mid_rst_D", n_seen[O_D], 0);
    check_eq("mid_rst_fault", {31'd0, fault}, 32'd0);
    check_eq("mid_rst_mode", {30'd0, mode}, 32'd0);
    check_eq("mid_rst_outs", {27'd0, P, N, R, D, reject}, 32'd0);
    reset = 1'b0;
    clear_obs();
    watch(30);
    check_eq("post_rst_D_first", first_seen[O_D], LAT);
    check_eq("post_rst_D_count", n_seen[O_D], 1);
    check_eq("post_rst_mode", {30'd0, mode}, 32'd3);
    b_d = 1'b0;
    idle(20);

    check_eq("one_hot", multi_hot, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gear_selector_input.md
GEAR_SELECTOR_INPUT -- requirements
Module: gear_selector_input

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 8: consecutive stable cycles needed to accept a new debounced level.
REQ-002 SHALL have parameter STUCK_CYCLES, default 1024: cycles a debounced button may stay high before a stuck fault is raised.
REQ-003 SHALL have port clk, input, 1 bit: single clock; one clock domain only.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports btn_p, btn_n, btn_r, btn_d, input, 1 bit each: raw, asynchronous, bouncing selector contacts, active-high.
REQ-006 SHALL have port brake, input, 1 bit: raw, asynchronous brake-pedal switch, active-high.
REQ-007 SHALL have ports P, N, R, D, output, 1 bit each: registered single-cycle command pulses to the gear FSM.
REQ-008 SHALL have port mode, output, 2 bits: shadow of the last issued mode, encoded P=00, N=01, R=10, D=11.
REQ-009 SHALL have port reject, output, 1 bit: single-cycle pulse when the interlock refuses a request.
REQ-010 SHALL have port fault, output, 1 bit: sticky stuck-button flag.

Function
REQ-011 SHALL pass each of the 5 raw inputs through a 2-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized input independently.
- Counter clears whenever the input equals the debounced level.
- When the counter reaches DEB_CYCLES with the input still differing, the debounced level toggles and the counter clears.
- Counter width is clog2(DEB_CYCLES+1); no wrap.
REQ-013 SHALL form a request only on a rising edge of a debounced button; holding a button generates no further requests.
REQ-014 SHALL resolve simultaneous rising edges in one cycle by priority P > N > R > D; lower-priority edges in that cycle are discarded.
REQ-015 SHALL grant a request equal to the current mode silently: no pulse, no reject.
REQ-016 SHALL apply the interlock using the debounced brake level in the request cycle.
- Leaving P (to N, R or D) requires brake=1.
- R to D and D to R require brake=1.
- Entering P, or entering N from any mode, is always allowed.
REQ-017 SHALL, for a granted request, pulse exactly one of P/N/R/D for one cycle and update mode in the same cycle.
REQ-018 SHALL, for a refused request, pulse reject for one cycle and leave mode and P/N/R/D unchanged.
REQ-019 SHALL have latency DEB_CYCLES+4 cycles from the first clock edge that samples a clean raw high to the command or reject pulse being visible.
REQ-020 SHALL set fault when any debounced button stays high for STUCK_CYCLES consecutive cycles.
- Per-button counter saturates at STUCK_CYCLES.
REQ-021 SHALL, while fault=1, suppress all requests except P; P is still granted per REQ-015/017.
REQ-022 SHALL clear fault only on reset.
REQ-023 SHALL have at most one of P, N, R, D, reject high in any cycle.

Reset
REQ-024 SHALL, on reset, asynchronously force P, N, R, D, reject and fault to 0 and mode to 00.
REQ-025 SHALL, on reset, asynchronously clear all synchronizer flops, debounced levels, edge registers and counters.
REQ-026 SHALL abort any in-progress debounce or pending pulse on reset mid-operation; after release, a button already held high is treated as a new press once debounced.

Structure
REQ-027 SHALL take the mode encoding constants (P/N/R/D = 00/01/10/11) from a shared package also used by the downstream gear FSM.
REQ-028 SHALL implement synchronizer plus debouncer as one sub-module, selector_debounce (parameter DEB_CYCLES), instantiated 5 times.
REQ-029 SHALL keep the request arbitration, interlock, mode shadow and stuck detection in the top level.

Verification (DEB_CYCLES=8, STUCK_CYCLES=64)
REQ-030 Release reset with brake=1, then press btn_d cleanly -> D pulses once, exactly 12 cycles after the first high sample; mode=11; reject stays 0.
REQ-031 btn_n toggling every 3 cycles for 30 cycles, then held high -> no output during bounce; N pulses once, 12 cycles after the bounce ends; mode=01.
REQ-032 From mode=00 with brake=0, press btn_r -> reject pulses once; mode stays 00; R stays 0. Repeat with brake=1 -> R pulses; mode=10.
REQ-033 btn_p and btn_d rise in the same cycle from mode=01 -> only P pulses; mode=00.
REQ-034 Hold btn_d for 100 cycles -> fault=1 by cycle 64+12; then btn_n press -> no pulse; btn_p press -> P pulses.
REQ-035 Assert reset 5 cycles into the btn_d debounce window -> no D pulse; all outputs 0 and mode=00; btn_d still held after release -> D pulses 12 cycles later if brake=1.
